// File: rtl/adt7301_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adt7301_pkg
// Description : Word geometry, state encoding and helpers shared by the
//               ADT7301 responder and the SPI master driver.
// Revision    : 1.0 - initial release
// ============================================================================
package adt7301_pkg;

  localparam int ADT_WORD_W   = 16;
  localparam int ADT_TEMP_W   = 14;
  localparam int ADT_SHDN_BIT = 13;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } adt_state_e;

  // Temperature register is 14-bit two's complement; the wire format
  // repeats the sign into the two top bits of the 16-bit frame.
  function automatic logic [ADT_WORD_W-1:0] adt_sign_extend(
    input logic [ADT_TEMP_W-1:0] t
  );
    return {{(ADT_WORD_W-ADT_TEMP_W){t[ADT_TEMP_W-1]}}, t};
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : sync_edge
// Description : N-stage synchronizer plus one history register; rise/fall
//               are decoded from the two registered samples.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_last;

  // Synchronizer chain followed by the register that feeds the edge detect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= {STAGES{RST_VAL}};
      r_last <= RST_VAL;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], d};
      r_last <= r_sync[STAGES-1];
    end
  end

  assign level = r_sync[STAGES-1];
  assign rise  = r_sync[STAGES-1] & ~r_last;
  assign fall  = ~r_sync[STAGES-1] & r_last;

endmodule
`default_nettype wire

// File: rtl/adt7301_responder.sv
`default_nettype none
// ============================================================================
// Module      : adt7301_responder
// Description : ADT7301 temperature-sensor emulator. Oversampled SPI slave
//               (CPOL=1) returning the sign-extended temperature register,
//               capturing the command word, with periodic conversion and a
//               shutdown bit that freezes conversions.
// Revision    : 1.0 - initial release
// ============================================================================
module adt7301_responder
  import adt7301_pkg::*;
#(
  parameter int CONV_CYCLES = 1_000_000,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADT_TEMP_W-1:0] temp_in,
  input  logic                  sclk,
  input  logic                  cs,
  input  logic                  mosi,
  output logic                  miso,
  output logic [ADT_WORD_W-1:0] rx_word,
  output logic                  rx_valid,
  output logic                  shutdown,
  output logic                  busy
);

  localparam int                c_conv_w    = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
  localparam logic [c_conv_w-1:0] c_conv_last = c_conv_w'(CONV_CYCLES - 1);
  localparam int                c_cnt_w     = $clog2(ADT_WORD_W + 1);
  localparam logic [c_cnt_w-1:0]  c_cnt_full  = c_cnt_w'(ADT_WORD_W);
  localparam logic [c_cnt_w-1:0]  c_cnt_last  = c_cnt_w'(ADT_WORD_W - 1);

  logic w_sclk_lvl, w_sclk_rise, w_sclk_fall;
  logic w_cs_lvl, w_cs_rise, w_cs_fall;
  logic w_mosi_lvl, w_mosi_rise, w_mosi_fall;
  logic w_unused;

  // sclk idles high. cs resets to "low" so a frame already in progress when
  // reset releases produces no falling edge and is ignored.
  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sclk (
    .clk(clk), .rst(rst), .d(sclk), .level(w_sclk_lvl), .rise(w_sclk_rise), .fall(w_sclk_fall)
  );
  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_cs (
    .clk(clk), .rst(rst), .d(cs), .level(w_cs_lvl), .rise(w_cs_rise), .fall(w_cs_fall)
  );
  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .d(mosi), .level(w_mosi_lvl), .rise(w_mosi_rise), .fall(w_mosi_fall)
  );

  assign w_unused = ^{w_sclk_lvl, w_cs_lvl, w_mosi_rise, w_mosi_fall};

  adt_state_e              r_state;
  logic [ADT_WORD_W-1:0]   r_shreg;
  logic [ADT_WORD_W-1:0]   r_rxreg;
  logic [c_cnt_w-1:0]      r_bitcnt;
  logic                    r_done;
  logic [ADT_TEMP_W-1:0]   r_temp;
  logic [c_conv_w-1:0]     r_conv_cnt;
  logic                    r_pending;
  logic [ADT_WORD_W-1:0]   w_rx_next;
  logic                    w_conv_due;
  logic                    w_hold;

  assign w_rx_next  = {r_rxreg[ADT_WORD_W-2:0], w_mosi_lvl};
  assign miso       = r_shreg[ADT_WORD_W-1];
  assign busy       = (r_state != IDLE);
  assign w_conv_due = !shutdown && (r_conv_cnt == c_conv_last);
  // A cs falling edge in the same cycle as a conversion counts as busy, so
  // the frame loads the old value and the update is deferred.
  assign w_hold     = busy | w_cs_fall;

  // Frame state machine: load on cs fall, shift on sclk edges, capture word.
  // shreg is loaded on the IDLE->LOAD transition so D15 reaches miso with
  // the same latency as every other edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_shreg  <= '0;
      r_rxreg  <= '0;
      r_bitcnt <= '0;
      r_done   <= 1'b0;
      rx_word  <= '0;
      rx_valid <= 1'b0;
      shutdown <= 1'b0;
    end else begin
      r_done   <= 1'b0;
      rx_valid <= r_done;
      case (r_state)
        IDLE: begin
          if (w_cs_fall) begin
            r_shreg  <= adt_sign_extend(r_temp);
            r_bitcnt <= '0;
            r_state  <= LOAD;
          end
        end
        LOAD: begin
          r_state <= SHIFT;
        end
        SHIFT: begin
          if (w_cs_rise) begin
            // Partial words are simply dropped; outputs keep the last word.
            r_state <= IDLE;
            r_shreg <= '0;
          end else begin
            if (w_sclk_rise && (r_bitcnt != c_cnt_full)) begin
              r_rxreg  <= w_rx_next;
              r_bitcnt <= r_bitcnt + c_cnt_w'(1);
              if (r_bitcnt == c_cnt_last) begin
                rx_word  <= w_rx_next;
                shutdown <= w_rx_next[ADT_SHDN_BIT];
                r_done   <= 1'b1;
              end
            end
            // The first falling edge is the CPOL=1 leading edge: keep D15.
            if (w_sclk_fall) begin
              if (r_bitcnt == c_cnt_full) begin
                r_shreg <= '0;
              end else if (r_bitcnt != '0) begin
                r_shreg <= {r_shreg[ADT_WORD_W-2:0], 1'b0};
              end
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Conversion timer and temperature register with deferred load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_conv_cnt <= '0;
      r_pending  <= 1'b0;
      r_temp     <= '0;
    end else begin
      if (!shutdown) begin
        r_conv_cnt <= w_conv_due ? '0 : (r_conv_cnt + c_conv_w'(1));
      end
      if (w_conv_due || r_pending) begin
        if (w_hold) begin
          r_pending <= 1'b1;
        end else begin
          r_temp    <= temp_in;
          r_pending <= 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_adt7301_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_adt7301_responder
// Description : Self-checking bench for adt7301_responder: SPI master driver,
//               frame-level behavioural model, idle-output monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adt7301_responder;

  localparam int CONV = 64;
  localparam int SYNC = 2;
  localparam int PH   = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [13:0] temp_in = '0;
  logic        sclk = 1'b1;
  logic        cs   = 1'b1;
  logic        mosi = 1'b0;
  logic        miso;
  logic [15:0] rx_word;
  logic        rx_valid;
  logic        shutdown;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // Model state: temperature the next frame must return, last command word.
  logic [13:0] m_temp = '0;
  logic [15:0] m_rx   = '0;
  logic        m_shdn = 1'b0;
  logic        settled = 1'b0;
  int          valid_cnt = 0;
  int          since_rst = 0;
  logic [15:0] got;

  always #5 clk = ~clk;

  adt7301_responder #(.CONV_CYCLES(CONV), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .temp_in(temp_in), .sclk(sclk), .cs(cs), .mosi(mosi),
    .miso(miso), .rx_word(rx_word), .rx_valid(rx_valid), .shutdown(shutdown), .busy(busy)
  );

  always @(posedge clk) since_rst <= rst ? 0 : since_rst + 1;
  always @(negedge clk) if (rx_valid) valid_cnt++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Between frames every output must sit at its quiescent model value.
  always @(negedge clk) begin
    if (settled) begin
      checks++;
      if (rx_word !== m_rx || shutdown !== m_shdn || busy !== 1'b0 ||
          miso !== 1'b0 || rx_valid !== 1'b0) begin
        errors++;
        if (errors <= 20)
          $display("FAIL idle_outputs t=%0t actual rx_word=%h shutdown=%b busy=%b miso=%b rx_valid=%b required rx_word=%h shutdown=%b busy=0 miso=0 rx_valid=0",
                   $time, rx_word, shutdown, busy, miso, rx_valid, m_rx, m_shdn);
      end
    end
  end

  task automatic frame(input logic [15:0] tx, input int nclk, input string name,
                       output logic [15:0] rd);
    logic [15:0] exp;
    logic [15:0] mask;
    int          vc0;
    exp     = 16'($signed(m_temp));
    settled = 1'b0;
    vc0     = valid_cnt;
    rd      = '0;
    cs = 1'b0;
    repeat (PH) @(negedge clk);
    for (int i = 0; i < nclk; i++) begin
      sclk = 1'b0;
      mosi = (i < 16) ? tx[15-i] : 1'($urandom_range(0, 1));
      repeat (PH) @(negedge clk);
      if (i < 16) rd[15-i] = miso;
      else        chk({name, "_extra_bit"}, {31'd0, miso}, 32'd0);
      sclk = 1'b1;
      repeat (PH) @(negedge clk);
    end
    cs = 1'b1;
    repeat (PH + SYNC + 4) @(negedge clk);
    mask = (nclk >= 16) ? 16'hFFFF : ~(16'hFFFF >> nclk);
    chk({name, "_miso_bits"}, {16'd0, rd & mask}, {16'd0, exp & mask});
    chk({name, "_rx_valid_pulses"}, valid_cnt - vc0, (nclk >= 16) ? 1 : 0);
    if (nclk >= 16) begin
      m_rx   = tx;
      m_shdn = tx[13];
    end
    settled = 1'b1;
  endtask

  task automatic do_reset();
    settled = 1'b0;
    @(negedge clk);
    rst = 1'b1; cs = 1'b1; sclk = 1'b1; mosi = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    m_rx = '0; m_shdn = 1'b0; m_temp = '0;
  endtask

  task automatic wait_until(input int n);
    while (since_rst < n) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    int n;
    int vc0;
    logic [15:0] w;

    // Reset values and first conversion.
    temp_in = 14'h0C80;
    do_reset();
    chk("reset_outputs", {13'd0, miso, rx_word, rx_valid, shutdown, busy}, 32'd0);
    settled = 1'b1;
    repeat (70) @(negedge clk);
    m_temp = temp_in;
    frame(16'h0000, 16, "read_pos", got);
    chk("lit_pos", {16'd0, got}, 32'h0C80);
    chk("lit_rx_word_zero", {16'd0, rx_word}, 32'd0);
    chk("lit_shdn_zero", {31'd0, shutdown}, 32'd0);

    // Negative temperature is sign extended.
    temp_in = 14'h3F60;
    repeat (2 * CONV) @(negedge clk);
    m_temp = temp_in;
    frame(16'h0000, 16, "read_neg", got);
    chk("lit_neg", {16'd0, got}, 32'hFF60);

    // Shutdown freezes conversions.
    frame(16'h2000, 16, "wr_shdn", got);
    chk("lit_shdn_set", {31'd0, shutdown}, 32'd1);
    temp_in = 14'h0100;
    repeat (3 * CONV) @(negedge clk);
    frame(16'h2000, 16, "rd_shdn", got);
    chk("lit_shdn_old", {16'd0, got}, 32'hFF60);
    frame(16'h0000, 16, "wr_wake", got);
    chk("lit_shdn_clr", {31'd0, shutdown}, 32'd0);
    repeat (2 * CONV) @(negedge clk);
    m_temp = temp_in;
    frame(16'h0000, 16, "rd_wake", got);
    chk("lit_wake_new", {16'd0, got}, 32'h0100);

    // Aborted and over-long frames.
    frame(16'hFFFF, 9, "abort", got);
    chk("lit_abort_rx", {16'd0, rx_word}, 32'd0);
    chk("lit_abort_shdn", {31'd0, shutdown}, 32'd0);
    frame(16'h1234, 20, "long", got);
    chk("lit_long_rx", {16'd0, rx_word}, 32'h1234);

    // Randomized command words and frame lengths.
    for (int k = 0; k < 24; k++) begin
      w = 16'($urandom);
      if ($urandom_range(0, 2) == 0) n = int'($urandom_range(1, 15));
      else                           n = int'($urandom_range(16, 20));
      frame(w, n, "rand", got);
    end

    // Conversion due mid-frame: current frame old, next frame new.
    temp_in = 14'h0155;
    do_reset();
    settled = 1'b1;
    wait_until(70);
    m_temp  = temp_in;
    temp_in = 14'h2AAA;
    wait_until(100);
    frame(16'h0000, 16, "mid_old", got);
    chk("lit_mid_old", {16'd0, got}, 32'h0155);
    m_temp = temp_in;
    frame(16'h0000, 16, "mid_new", got);
    chk("lit_mid_new", {16'd0, got}, 32'hEAAA);

    // Conversion coincides with the detected cs falling edge.
    temp_in = 14'h0155;
    do_reset();
    settled = 1'b1;
    wait_until(70);
    m_temp  = temp_in;
    temp_in = 14'h2AAA;
    wait_until(CONV * 2 - SYNC - 1);
    frame(16'h0000, 16, "coin_old", got);
    chk("lit_coin_old", {16'd0, got}, 32'h0155);
    m_temp = temp_in;
    frame(16'h2C3C, 16, "coin_new", got);
    chk("lit_coin_new", {16'd0, got}, 32'hEAAA);
    chk("lit_coin_shdn", {31'd0, shutdown}, 32'd1);

    // Reset in the middle of a frame; the remainder is ignored.
    settled = 1'b0;
    temp_in = 14'h0C80;
    cs = 1'b0;
    repeat (PH) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      sclk = 1'b0; mosi = 1'b1;
      repeat (PH) @(negedge clk);
      sclk = 1'b1;
      repeat (PH) @(negedge clk);
    end
    rst = 1'b1;
    #1;
    chk("rst_async_outputs", {13'd0, miso, rx_word, rx_valid, shutdown, busy}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_rx = '0; m_shdn = 1'b0; m_temp = '0;
    vc0 = valid_cnt;
    for (int i = 0; i < 8; i++) begin
      sclk = 1'b0;
      repeat (PH) @(negedge clk);
      chk("post_rst_quiet", {30'd0, miso, busy}, 32'd0);
      sclk = 1'b1;
      repeat (PH) @(negedge clk);
    end
    cs = 1'b1;
    repeat (PH + SYNC + 4) @(negedge clk);
    chk("post_rst_no_valid", valid_cnt - vc0, 0);
    settled = 1'b1;
    repeat (2 * CONV) @(negedge clk);
    m_temp = temp_in;
    frame(16'h0000, 16, "after_rst", got);
    chk("lit_after_rst", {16'd0, got}, 32'h0C80);

    settled = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
